// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding,
// default ALU widths and the select codes requesters put on req_sel.
package alu_arb_pkg;

    localparam int unsigned ALU_DATA_W = 4;
    localparam int unsigned ALU_SEL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Select codes understood by the shared ALU
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 2'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_AND = 2'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 2'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 2'd3;

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: grants the first set request found
// after last_grant, wrapping modulo NUM_REQ.
module rr_priority_sel #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        // Search starts one past the previous winner so it ends up lowest priority
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant) + k) % NUM_REQ;
            if (!found && ((req >> idx) & NUM_REQ'(1)) != '0) begin
                found     = 1'b1;
                grant     = NUM_REQ'(1) << idx;
                grant_idx = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters: accepts one
// operation at a time, runs it for a cycle, and holds the tagged result.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned SEL_W   = ALU_SEL_W,
    parameter int unsigned ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_select,
    input  logic [DATA_W-1:0]         alu_output,
    input  logic                      alu_carry_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_carry
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_carry_q, rsp_carry_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   win_a, win_b;
    logic [SEL_W-1:0]    win_sel;

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_sel (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Winner's operand slices out of the flattened request buses
    assign win_a   = DATA_W'(req_a   >> (32'(grant_idx) * DATA_W));
    assign win_b   = DATA_W'(req_b   >> (32'(grant_idx) * DATA_W));
    assign win_sel = SEL_W'(req_sel  >> (32'(grant_idx) * SEL_W));

    // Gated by reset_L so nothing looks accepted while reset is being applied
    assign req_ready = (reset_L && state_q == ST_IDLE) ? grant : '0;

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_select = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    a_d          = win_a;
                    b_d          = win_b;
                    sel_d        = win_sel;
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_output;
                rsp_carry_d = alu_carry_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push hand-computed
// responses; a negedge monitor pops and compares on each response handshake.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
        logic       c;
    } rsp_t;

    logic        clk;
    logic        reset_L;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_sel;
    logic [3:0]  req_ready;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_select;
    logic [3:0]  alu_output;
    logic        alu_carry_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        rsp_carry;

    rsp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic cont   = 1'b0;

    alu_arbiter dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_sel       (req_sel),
        .req_ready     (req_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_select    (alu_select),
        .alu_output    (alu_output),
        .alu_carry_out (alu_carry_out),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_carry     (rsp_carry)
    );

    // Stand-in for the external ALU
    always_comb begin
        logic [4:0] r;
        case (alu_select)
            ALU_ADD: r = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_AND: r = {1'b0, alu_a & alu_b};
            ALU_SUB: r = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            default: r = {1'b0, alu_a ^ alu_b};
        endcase
        alu_output    = r[3:0];
        alu_carry_out = r[4];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_L === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp", 32'({rsp_id, rsp_data, rsp_carry}), 32'(e));
            end
        end
    end

    // One clock: sample accepts before the edge, drop accepted one-shot requests after it
    task automatic step(output logic [3:0] acc);
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (!cont) req_valid = req_valid & ~acc;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        req_a[i*4 +: 4]   = a;
        req_b[i*4 +: 4]   = b;
        req_sel[i*2 +: 2] = s;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int c = 0; c < 20 && g == '0; c++) step(g);
    endtask

    task automatic drain(input string nm);
        logic [3:0] a;
        for (int c = 0; c < 30 && (exp_q.size() != 0 || rsp_valid); c++) step(a);
        chk(nm, 32'(exp_q.size() == 0 && !rsp_valid), 32'd1);
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] g_vec[5];
        int         g_cyc[5];
        int         order[5];
        int         n_g;
        int         extra;

        reset_L   = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;

        // Reset with every requester valid
        step(g);
        step(g);
        chk("t1_ready_in_reset", 32'(req_ready), 32'h0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("t1_alu_ops", 32'({alu_a, alu_b, alu_select}), 32'h0);
        chk("t1_rsp_fields", 32'({rsp_id, rsp_data, rsp_carry}), 32'h0);
        reset_L = 1'b1;
        #1;
        chk("t1_ready_after", 32'(req_ready), 32'b0001);
        req_valid = '0;

        // Single request from requester 2: 1 - E = 3, borrow so carry 0
        rsp_ready = 1'b1;
        set_req(2, 4'h1, 4'hE, ALU_SUB);
        exp_q.push_back('{id: 2'd2, data: 4'h3, c: 1'b0});
        wait_grant(g);
        chk("t2_grant", 32'(g), 32'b0100);
        chk("t2_alu_ops", 32'({alu_a, alu_b, alu_select}), 32'({4'h1, 4'hE, 2'd2}));
        step(g);
        chk("t2_latency", 32'(rsp_valid), 32'd1);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            step(g);
            if (g != '0) extra++;
        end
        chk("t2_once", 32'(extra), 32'd0);
        drain("t2_drain");

        // Round robin with all valid, starting from a fresh reset
        reset_L = 1'b0;
        step(g);
        reset_L = 1'b1;
        set_req(0, 4'h3, 4'h4, ALU_ADD);
        set_req(1, 4'h9, 4'h8, ALU_ADD);
        set_req(2, 4'h5, 4'hC, ALU_SUB);
        set_req(3, 4'hA, 4'h6, ALU_XOR);
        cont = 1'b1;
        exp_q.push_back('{id: 2'd0, data: 4'h7, c: 1'b0});
        exp_q.push_back('{id: 2'd1, data: 4'h1, c: 1'b1});
        exp_q.push_back('{id: 2'd2, data: 4'h9, c: 1'b0});
        exp_q.push_back('{id: 2'd3, data: 4'hC, c: 1'b0});
        exp_q.push_back('{id: 2'd0, data: 4'h7, c: 1'b0});
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        n_g = 0;
        for (int c = 0; c < 60 && n_g < 5; c++) begin
            step(g);
            if (g != '0) begin
                g_vec[n_g] = g;
                g_cyc[n_g] = c;
                n_g++;
            end
        end
        cont      = 1'b0;
        req_valid = '0;
        chk("t3_count", 32'(n_g), 32'd5);
        for (int k = 0; k < n_g; k++) chk("t3_grant", 32'(g_vec[k]), 32'd1 << order[k]);
        for (int k = 0; k + 1 < n_g; k++) chk("t3_interval", 32'(g_cyc[k+1] - g_cyc[k]), 32'd3);
        drain("t3_drain");

        // Back-pressure on requester 1: F + F = 1E
        rsp_ready = 1'b0;
        set_req(1, 4'hF, 4'hF, ALU_ADD);
        exp_q.push_back('{id: 2'd1, data: 4'hE, c: 1'b1});
        wait_grant(g);
        chk("t4_grant_r1", 32'(g), 32'b0010);
        step(g);
        set_req(0, 4'h3, 4'h4, ALU_ADD);
        set_req(2, 4'h5, 4'hC, ALU_SUB);
        exp_q.push_back('{id: 2'd2, data: 4'h9, c: 1'b0});
        exp_q.push_back('{id: 2'd0, data: 4'h7, c: 1'b0});
        for (int c = 0; c < 5; c++) begin
            step(g);
            chk("t4_hold", 32'({rsp_valid, rsp_id, rsp_data, rsp_carry, req_ready}),
                32'({1'b1, 2'd1, 4'hE, 1'b1, 4'h0}));
        end
        rsp_ready = 1'b1;
        wait_grant(g);
        chk("t4_next_r2", 32'(g), 32'b0100);
        wait_grant(g);
        chk("t4_then_r0", 32'(g), 32'b0001);
        drain("t4_drain");

        // Wrap-around: move last_grant to 3, then requesters 0 and 3 compete
        set_req(3, 4'hA, 4'h6, ALU_XOR);
        exp_q.push_back('{id: 2'd3, data: 4'hC, c: 1'b0});
        wait_grant(g);
        chk("t5_setup_r3", 32'(g), 32'b1000);
        drain("t5_setup_drain");
        set_req(0, 4'h9, 4'h8, ALU_ADD);
        set_req(3, 4'h2, 4'h7, ALU_SUB);
        exp_q.push_back('{id: 2'd0, data: 4'h1, c: 1'b1});
        exp_q.push_back('{id: 2'd3, data: 4'hB, c: 1'b0});
        wait_grant(g);
        chk("t5_wrap_r0", 32'(g), 32'b0001);
        wait_grant(g);
        chk("t5_then_r3", 32'(g), 32'b1000);
        drain("t5_drain");

        // Reset during EXEC: the in-flight request must never respond
        set_req(1, 4'h4, 4'h4, ALU_ADD);
        wait_grant(g);
        chk("t6_grant_r1", 32'(g), 32'b0010);
        reset_L = 1'b0;
        step(g);
        chk("t6_aborted", 32'({rsp_valid, alu_a, alu_b, alu_select}), 32'h0);
        reset_L = 1'b1;
        set_req(0, 4'hC, 4'h3, ALU_ADD);
        set_req(2, 4'h1, 4'h1, ALU_ADD);
        exp_q.push_back('{id: 2'd0, data: 4'hF, c: 1'b0});
        exp_q.push_back('{id: 2'd2, data: 4'h2, c: 1'b0});
        #1;
        chk("t6_ready_r0", 32'(req_ready), 32'b0001);
        wait_grant(g);
        chk("t6_grant_r0", 32'(g), 32'b0001);
        wait_grant(g);
        chk("t6_grant_r2", 32'(g), 32'b0100);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
